opc_intctl: RTL and testbench

Parametrised interrupt controller for the OPC CPU family; it generalises the CPU's fixed two-line `int_b[1:0]` request scheme to `NCHAN` sources. Features: per-channel enable, edge/level mode, two priority groups and nested in-service tracking. It sits on the CPU's I/O space (`vio` cycles) and drives the CPU's `int_b[1:0]` directly. Software claims a channel by reading a vector register and ends service with an EOI write.

---
 rtl/opc_intctl.sv | 139 +++++++++++++
 tb/tb_opc_intctl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opc_intctl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : opc_intctl
// Brief    : NCHAN-source interrupt controller for the OPC CPU I/O space.
//            Per-channel enable, edge/level mode, two priority groups and
//            nested in-service tracking, driving the CPU's int_b[1:0].
// Revision : 1.0 - initial release
// ============================================================================
module opc_intctl #(
  parameter int NCHAN = 8,
  parameter int DW    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clken,
  input  logic [NCHAN-1:0] irq,
  input  logic             cs,
  input  logic             rnw,
  input  logic [2:0]       addr,
  input  logic [DW-1:0]    din,
  output logic [DW-1:0]    dout,
  output logic [1:0]       int_b
);

  localparam int IDW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  localparam logic [2:0] A_ENABLE  = 3'd0;
  localparam logic [2:0] A_PENDING = 3'd1;
  localparam logic [2:0] A_MODE    = 3'd2;
  localparam logic [2:0] A_GROUP   = 3'd3;
  localparam logic [2:0] A_CLAIM   = 3'd4;
  localparam logic [2:0] A_EOI     = 3'd5;
  localparam logic [2:0] A_INSERV  = 3'd6;
  localparam logic [2:0] A_VBASE   = 3'd7;

  logic [NCHAN-1:0] sync1, s, s_q;
  logic [NCHAN-1:0] enable, pending, mode, group, inserv;
  logic [DW-1:0]    vbase;

  logic [NCHAN-1:0] wdata, rise, cand, lowbit, below, elig;
  logic [NCHAN-1:0] claim_mask, eoi_mask, clr_mask, mode_chg;
  logic [NCHAN-1:0] pending_nxt, inserv_nxt;
  logic             wr_en, any_elig, claim_fire;
  logic [IDW-1:0]   claim_id;
  logic [DW-1:0]    claim_val;

  assign wdata    = din[NCHAN-1:0];
  assign wr_en    = cs & ~rnw & clken;
  assign rise     = s & ~s_q;
  assign cand     = pending & enable & ~inserv;

  // Mask of indices strictly below the lowest in-service channel; with
  // nothing in service the subtraction wraps to all-ones.
  assign lowbit   = inserv & (~inserv + NCHAN'(1));
  assign below    = lowbit - NCHAN'(1);
  assign elig     = cand & below;
  assign any_elig = |elig;

  // A claim only takes effect on an enabled edge and when someone is eligible.
  assign claim_fire = cs & rnw & (addr == A_CLAIM) & clken & any_elig;
  assign claim_mask = claim_fire ? (elig & (~elig + NCHAN'(1))) : '0;
  assign claim_val  = vbase + (DW'(claim_id) << 1);

  assign clr_mask   = ((wr_en && addr == A_PENDING) ? wdata : '0) | claim_mask;
  assign mode_chg   = (wr_en && addr == A_MODE) ? (wdata ^ mode) : '0;

  // Edge bits: set wins over clear. Level bits simply track s.
  assign pending_nxt = ((mode & ((pending & ~clr_mask) | rise)) | (~mode & s)) & ~mode_chg;
  // Claim wins over a same-cycle EOI of the same id.
  assign inserv_nxt  = (inserv & ~eoi_mask) | claim_mask;

  // Lowest-index eligible channel id.
  always_comb begin
    claim_id = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (elig[i]) claim_id = IDW'(i);
    end
  end

  // One-hot EOI target; ids outside the channel range match nothing.
  always_comb begin
    eoi_mask = '0;
    for (int i = 0; i < NCHAN; i++) begin
      eoi_mask[i] = wr_en && (addr == A_EOI) && ({28'd0, din[3:0]} == 32'(i));
    end
  end

  // Synchronisers, status, configuration and the registered CPU request lines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= '0;
      s       <= '0;
      s_q     <= '0;
      pending <= '0;
      inserv  <= '0;
      enable  <= '0;
      mode    <= '0;
      group   <= '0;
      vbase   <= '0;
      int_b   <= 2'b11;
    end else if (clken) begin
      sync1   <= irq;
      s       <= sync1;
      s_q     <= s;
      pending <= pending_nxt;
      inserv  <= inserv_nxt;
      int_b   <= {~|(elig & group), ~|(elig & ~group)};
      if (wr_en) begin
        case (addr)
          A_ENABLE: enable <= wdata;
          A_MODE:   mode   <= wdata;
          A_GROUP:  group  <= wdata;
          A_VBASE:  vbase  <= din;
          default:  ;
        endcase
      end
    end
  end

  // Combinational read mux; idle bus reads as zero.
  always_comb begin
    dout = '0;
    if (cs) begin
      case (addr)
        A_ENABLE:  dout = DW'(enable);
        A_PENDING: dout = DW'(pending);
        A_MODE:    dout = DW'(mode);
        A_GROUP:   dout = DW'(group);
        A_CLAIM:   dout = any_elig ? claim_val : '1;
        A_INSERV:  dout = DW'(inserv);
        A_VBASE:   dout = vbase;
        default:   dout = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_opc_intctl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_opc_intctl
// Brief    : Self-checking bench for opc_intctl with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_opc_intctl;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        reset, clken, cs, rnw;
  logic [2:0]  addr;
  logic [15:0] din;
  logic [7:0]  irq;
  logic [15:0] irq16;
  logic [0:0]  irq1;
  logic [15:0] dout, dout16, dout1;
  logic [1:0]  int_b, int_b16, int_b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  opc_intctl #(.NCHAN(8), .DW(16)) dut (
    .clk(clk), .reset(reset), .clken(clken), .irq(irq), .cs(cs), .rnw(rnw),
    .addr(addr), .din(din), .dout(dout), .int_b(int_b));

  opc_intctl #(.NCHAN(16), .DW(16)) dut16 (
    .clk(clk), .reset(reset), .clken(clken), .irq(irq16), .cs(cs), .rnw(rnw),
    .addr(addr), .din(din), .dout(dout16), .int_b(int_b16));

  opc_intctl #(.NCHAN(1), .DW(16)) dut1 (
    .clk(clk), .reset(reset), .clken(clken), .irq(irq1), .cs(cs), .rnw(rnw),
    .addr(addr), .din(din), .dout(dout1), .int_b(int_b1));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  m_en, m_pend, m_mode, m_grp, m_ins;
  logic [15:0] m_vb;
  logic [7:0]  h0, h1, h2;          // irq samples: last, one before, two before
  logic [1:0]  m_intb;
  logic [7:0]  np, ni;
  int          mw;
  logic        m_claim, m_eoi;

  // Lowest requesting channel that beats everything currently in service.
  function automatic int m_winner();
    for (int i = 0; i < N; i++) begin
      if (m_ins[i]) return -1;
      if (m_pend[i] && m_en[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic m_grp_req(input logic g);
    for (int i = 0; i < N; i++) begin
      if (m_ins[i]) return 1'b0;
      if (m_pend[i] && m_en[i] && m_grp[i] == g) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [15:0] m_dout();
    int w;
    if (!cs) return 16'h0000;
    case (addr)
      3'd0: return {8'h00, m_en};
      3'd1: return {8'h00, m_pend};
      3'd2: return {8'h00, m_mode};
      3'd3: return {8'h00, m_grp};
      3'd4: begin
        w = m_winner();
        return (w < 0) ? 16'hFFFF : m_vb + 16'(2 * w);
      end
      3'd6: return {8'h00, m_ins};
      3'd7: return m_vb;
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_en = 0; m_pend = 0; m_mode = 0; m_grp = 0; m_ins = 0; m_vb = 0;
      h0 = 0; h1 = 0; h2 = 0; m_intb = 2'b11;
    end else if (clken) begin
      mw      = m_winner();
      m_intb  = {~m_grp_req(1'b1), ~m_grp_req(1'b0)};
      m_claim = cs && rnw && addr == 3'd4 && mw >= 0;
      m_eoi   = cs && !rnw && addr == 3'd5;
      for (int i = 0; i < N; i++) begin
        if (m_mode[i]) begin
          np[i] = m_pend[i];
          if (cs && !rnw && addr == 3'd1 && din[i]) np[i] = 1'b0;
          if (m_claim && mw == i) np[i] = 1'b0;
          if (h1[i] && !h2[i]) np[i] = 1'b1;
        end else begin
          np[i] = h1[i];
        end
        if (cs && !rnw && addr == 3'd2 && din[i] != m_mode[i]) np[i] = 1'b0;
        ni[i] = m_ins[i];
        if (m_eoi && din[3:0] == i) ni[i] = 1'b0;
        if (m_claim && mw == i) ni[i] = 1'b1;
      end
      m_pend = np;
      m_ins  = ni;
      if (cs && !rnw) begin
        case (addr)
          3'd0: m_en   = din[7:0];
          3'd2: m_mode = din[7:0];
          3'd3: m_grp  = din[7:0];
          3'd7: m_vb   = din;
          default: ;
        endcase
      end
      h2 = h1; h1 = h0; h0 = irq;
    end
  end

  // Continuous compare against the model, away from the active edge.
  always @(negedge clk) begin
    check("int_b_model", {30'd0, int_b}, {30'd0, m_intb});
    if (cs) check("dout_model", {16'd0, dout}, {16'd0, m_dout()});
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    cs = 1'b1; rnw = 1'b0; addr = a; din = d;
    tick(1);
    cs = 1'b0; rnw = 1'b1;
  endtask

  task automatic rd(input string nm, input logic [2:0] a, input logic [15:0] exp);
    cs = 1'b1; rnw = 1'b1; addr = a;
    #1;
    check(nm, {16'd0, dout}, {16'd0, exp});
    tick(1);
    cs = 1'b0;
  endtask

  initial begin
    reset = 1'b0; clken = 1'b1; cs = 1'b0; rnw = 1'b1; addr = 3'd0; din = 16'h0;
    irq = 8'h00; irq16 = 16'h0; irq1 = 1'b0;
    #1 reset = 1'b1;
    #2;
    check("rst_int_b", {30'd0, int_b}, 32'h3);
    check("rst_int_b16", {30'd0, int_b16}, 32'h3);
    check("rst_int_b1", {30'd0, int_b1}, 32'h3);
    check("rst_dout", {16'd0, dout}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick(2);

    // Edge channel 3, low group
    wr(3'd0, 16'h0008);
    wr(3'd2, 16'h0008);
    wr(3'd7, 16'h0100);
    irq[3] = 1'b1;
    tick(3);
    check("edge_e3_idle", {30'd0, int_b}, 32'h3);
    irq[3] = 1'b0;
    tick(1);
    check("edge_e4_req", {30'd0, int_b}, 32'h2);
    rd("claim_ch3", 3'd4, 16'h0106);
    rd("pend_after_claim", 3'd1, 16'h0000);
    rd("inserv_after_claim", 3'd6, 16'h0008);
    check("int_b_after_claim", {30'd0, int_b}, 32'h3);

    // Nesting under channel 3
    wr(3'd3, 16'h0002);
    wr(3'd0, 16'h002A);
    irq = 8'h22;
    tick(4);
    check("nest_int_b", {30'd0, int_b}, 32'h1);
    rd("nest_claim", 3'd4, 16'h0102);
    irq = 8'h20;
    tick(3);
    wr(3'd5, 16'h0001);
    tick(2);
    check("eoi1_blocked", {30'd0, int_b}, 32'h3);
    wr(3'd5, 16'h0003);
    check("eoi3_lat", {30'd0, int_b}, 32'h3);
    tick(1);
    check("eoi3_unblock", {30'd0, int_b}, 32'h2);
    rd("claim_ch5", 3'd4, 16'h010A);
    irq = 8'h00;
    tick(3);

    // Empty claim
    rd("empty_claim", 3'd4, 16'hFFFF);
    rd("inserv_unch", 3'd6, 16'h0020);
    wr(3'd5, 16'h0005);
    rd("inserv_clr", 3'd6, 16'h0000);

    // Claim read without clock enable has no side effect
    irq[3] = 1'b1;
    tick(4);
    irq[3] = 1'b0;
    check("ch3_again", {30'd0, int_b}, 32'h2);
    clken = 1'b0;
    rd("claim_noclk", 3'd4, 16'h0106);
    clken = 1'b1;
    rd("inserv_noclk", 3'd6, 16'h0000);
    rd("pend_noclk", 3'd1, 16'h0008);
    wr(3'd1, 16'h0008);
    tick(1);
    check("pend_w1c", {30'd0, int_b}, 32'h3);
    rd("pend_cleared", 3'd1, 16'h0000);

    // Same-cycle claim and new edge on channel 2
    wr(3'd0, 16'h000C);
    wr(3'd2, 16'h000C);
    irq[2] = 1'b1;
    tick(4);
    check("ch2_int", {30'd0, int_b}, 32'h2);
    irq[2] = 1'b0;
    tick(3);
    irq[2] = 1'b1;
    tick(2);
    rd("same_claim", 3'd4, 16'h0104);
    irq[2] = 1'b0;
    rd("same_inserv", 3'd6, 16'h0004);
    rd("same_pend", 3'd1, 16'h0004);
    check("same_busy", {30'd0, int_b}, 32'h3);
    wr(3'd5, 16'h000F);
    rd("eoi15_ign", 3'd6, 16'h0004);
    wr(3'd5, 16'h0002);
    tick(1);
    check("eoi2_reassert", {30'd0, int_b}, 32'h2);
    wr(3'd2, 16'h0008);
    rd("mode_clr", 3'd1, 16'h0000);

    // Width masking across configurations
    wr(3'd0, 16'hFFFF);
    cs = 1'b1; rnw = 1'b1; addr = 3'd0;
    #1;
    check("en_w8", {16'd0, dout}, 32'h00FF);
    check("en_w16", {16'd0, dout16}, 32'hFFFF);
    check("en_w1", {16'd0, dout1}, 32'h0001);
    tick(1);
    cs = 1'b0;

    // Asynchronous reset mid-service
    wr(3'd3, 16'h00F0);
    irq = 8'hFF;
    tick(4);
    check("pre_reset", {30'd0, int_b}, 32'h0);
    #2 reset = 1'b1;
    #1;
    check("async_reset", {30'd0, int_b}, 32'h3);
    irq = 8'h00;
    @(posedge clk); #1;
    reset = 1'b0;
    rd("reset_enable", 3'd0, 16'h0000);
    rd("reset_pending", 3'd1, 16'h0000);
    rd("reset_mode", 3'd2, 16'h0000);
    rd("reset_group", 3'd3, 16'h0000);
    rd("reset_claim", 3'd4, 16'hFFFF);
    rd("reset_inserv", 3'd6, 16'h0000);
    rd("reset_vbase", 3'd7, 16'h0000);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
